// File: rtl/simple_cpu_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package simple_cpu_pkg;

   typedef logic port_id_t;

   typedef enum logic [1:0] {
      OPEN = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } lock_state_t;

   localparam int unsigned READ_LATENCY = 2;

   typedef struct packed {
      logic     valid;
      port_id_t port;
   } rd_tag_t;

   // Ports allowed to be granted while the lock FSM is in a given state.
   function automatic logic [1:0] lock_mask(input lock_state_t st);
      logic [1:0] m;
      case (st)
         OPEN:    m = 2'b11;
         OWN0:    m = 2'b01;
         OWN1:    m = 2'b10;
         default: m = 2'b11;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port not granted last wins.
module rr_pick2
   import simple_cpu_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_id_t   last_i,
   input  logic [1:0] mask_i,
   output logic [1:0] gnt_o
);

   logic [1:0] eff_s;

   // One-hot grant from the masked request vector.
   always_comb begin
      eff_s = req_i & mask_i;
      case (eff_s)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_i == 1'b1) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with read tagging.
// Optional ownership locking is built when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter
   import simple_cpu_pkg::*;
#(
   parameter int WIDTH_D = 32,
   parameter int DEPTH_D = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               req1,
   input  logic               we0,
   input  logic               we1,
   input  logic [DEPTH_D-1:0] addr0,
   input  logic [DEPTH_D-1:0] addr1,
   input  logic [WIDTH_D-1:0] wdata0,
   input  logic [WIDTH_D-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
   input  logic               lock0,
   input  logic               lock1,
`endif
   output logic               gnt0,
   output logic               gnt1,
   output logic               rvalid0,
   output logic               rvalid1,
   output logic [WIDTH_D-1:0] rdata,
   output logic [DEPTH_D-1:0] mem_addr,
   output logic [WIDTH_D-1:0] mem_i,
   output logic               mem_we,
   input  logic [WIDTH_D-1:0] mem_o
);

   logic [1:0]         pick_s;
   logic [1:0]         gnt_s;
   logic [1:0]         mask_s;
   logic               accept_s;
   port_id_t           sel_s;

   logic [DEPTH_D-1:0] mem_addr_d, mem_addr_q;
   logic [WIDTH_D-1:0] mem_i_d,    mem_i_q;
   logic               mem_we_d,   mem_we_q;
   port_id_t           last_d,     last_q;
   rd_tag_t            tag_d,      tag_q;
   logic               rvalid0_d,  rvalid0_q;
   logic               rvalid1_d,  rvalid1_q;

`ifdef DMEM_ARB_LOCK_EN
   lock_state_t        state_d,    state_q;
   logic               lock_sel_s;

   // Lock ownership: taken on a locked accept, released on an unlocked accept by the owner.
   always_comb begin
      lock_sel_s = (sel_s == 1'b1) ? lock1 : lock0;
      state_d    = state_q;
      case (state_q)
         OPEN: begin
            if (accept_s && lock_sel_s) begin
               state_d = (sel_s == 1'b1) ? OWN1 : OWN0;
            end else begin
               state_d = OPEN;
            end
         end
         OWN0: begin
            if (accept_s && (sel_s == 1'b0) && !lock0) begin
               state_d = OPEN;
            end else begin
               state_d = OWN0;
            end
         end
         OWN1: begin
            if (accept_s && (sel_s == 1'b1) && !lock1) begin
               state_d = OPEN;
            end else begin
               state_d = OWN1;
            end
         end
         default: state_d = OPEN;
      endcase
      mask_s = lock_mask(state_q);
   end

   // Lock state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= OPEN;
      end else begin
         state_q <= state_d;
      end
   end
`else
   assign mask_s = 2'b11;
`endif

   rr_pick2 u_pick (
      .req_i  ({req1, req0}),
      .last_i (last_q),
      .mask_i (mask_s),
      .gnt_o  (pick_s)
   );

   // Grants are suppressed while reset is held.
   always_comb begin
      gnt_s    = pick_s & {2{reset}};
      accept_s = gnt_s[0] | gnt_s[1];
      sel_s    = gnt_s[1];
   end

   // Memory-side register, tag pipe and round-robin history next-state.
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_i_d    = mem_i_q;
      mem_we_d   = 1'b0;
      last_d     = last_q;
      tag_d      = '{valid: 1'b0, port: 1'b0};
      if (accept_s) begin
         last_d     = sel_s;
         mem_addr_d = (sel_s == 1'b1) ? addr1  : addr0;
         mem_i_d    = (sel_s == 1'b1) ? wdata1 : wdata0;
         mem_we_d   = (sel_s == 1'b1) ? we1    : we0;
         tag_d      = '{valid: ~mem_we_d, port: sel_s};
      end else begin
         tag_d      = '{valid: 1'b0, port: 1'b0};
      end
      rvalid0_d = tag_q.valid & (tag_q.port == 1'b0);
      rvalid1_d = tag_q.valid & (tag_q.port == 1'b1);
   end

   // Datapath and pipeline registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr_q <= '0;
         mem_i_q    <= '0;
         mem_we_q   <= 1'b0;
         last_q     <= 1'b1;
         tag_q      <= '{valid: 1'b0, port: 1'b0};
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_i_q    <= mem_i_d;
         mem_we_q   <= mem_we_d;
         last_q     <= last_d;
         tag_q      <= tag_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
      end
   end

   assign gnt0     = gnt_s[0];
   assign gnt1     = gnt_s[1];
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata    = mem_o;
   assign mem_addr = mem_addr_q;
   assign mem_i    = mem_i_q;
   assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dmem_arbiter;
   import simple_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [7:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        lock0, lock1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata, mem_i, mem_o;
   logic [7:0]  mem_addr;
   logic        mem_we;

   logic [31:0] ram   [256];
   logic [31:0] model [256];

   typedef struct {
      int          due;
      bit          port;
      logic [31:0] data;
   } sb_entry_t;
   sb_entry_t sb[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   dmem_arbiter #(.WIDTH_D(32), .DEPTH_D(8)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef DMEM_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_i(mem_i), .mem_we(mem_we),
      .mem_o(mem_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_i;
      mem_o <= ram[mem_addr];
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: record accepts in grant order, check read returns on their due cycle.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
      end else begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            sb_entry_t e;
            e = sb.pop_front();
            check_eq("rvalid0", {31'd0, rvalid0}, {31'd0, ~e.port});
            check_eq("rvalid1", {31'd0, rvalid1}, {31'd0, e.port});
            check_eq("rdata", rdata, e.data);
         end else begin
            check_eq("no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
         end
         if (gnt0 && gnt1) check_eq("gnt_onehot", {30'd0, gnt1, gnt0}, 32'd1);
         if (gnt0 || gnt1) begin
            bit          p;
            logic        w;
            logic [7:0]  a;
            logic [31:0] d;
            p = gnt1;
            w = p ? we1 : we0;
            a = p ? addr1 : addr0;
            d = p ? wdata1 : wdata0;
            if (w) model[a] = d;
            else   sb.push_back('{due: cyc + READ_LATENCY, port: p, data: model[a]});
         end
      end
   end

   task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
      @(posedge clk);
      #1;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]   = 32'hA500_0000 | i;
         model[i] = 32'hA500_0000 | i;
      end
      reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 32'h0; wdata1 = 32'h0;
      lock0 = 1'b0; lock1 = 1'b0;
      #22;
      check_eq("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      check_eq("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      check_eq("rst_mem_i", mem_i, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Continuous tie: alternate grants starting with port 0.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0);
         check_eq("alt_gnt0", {31'd0, gnt0}, {31'd0, (i % 2) == 0});
         check_eq("alt_gnt1", {31'd0, gnt1}, {31'd0, (i % 2) == 1});
      end
      idle(3);

      // Port 0 write then read back.
      step(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00, 32'h0);
      check_eq("wr_gnt0", {31'd0, gnt0}, 32'd1);
      step(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      check_eq("rd_gnt0", {31'd0, gnt0}, 32'd1);
      idle(3);

      // Port 1 write immediately followed by port 0 read of the same word.
      step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h20, 32'h0000_0055);
      check_eq("raw_gnt1", {31'd0, gnt1}, 32'd1);
      step(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      check_eq("raw_gnt0", {31'd0, gnt0}, 32'd1);
      idle(3);

      // Single port back-to-back, mixed writes and reads.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, (i % 2) == 0, 8'h40 + 8'(i / 2), 32'h1000 + i);
         check_eq("b2b_gnt1", {31'd0, gnt1}, 32'd1);
      end
      idle(3);

`ifdef DMEM_ARB_LOCK_EN
      // Port 0 locks for three accesses while port 1 waits.
      lock0 = 1'b1;
      step(1'b1, 1'b0, 8'h05, 32'h0, 1'b1, 1'b0, 8'h06, 32'h0);
      check_eq("lk_gnt0_a", {30'd0, gnt1, gnt0}, 32'd1);
      step(1'b1, 1'b1, 8'h07, 32'h77, 1'b1, 1'b0, 8'h06, 32'h0);
      check_eq("lk_gnt0_b", {30'd0, gnt1, gnt0}, 32'd1);
      lock0 = 1'b0;
      step(1'b1, 1'b0, 8'h07, 32'h0, 1'b1, 1'b0, 8'h06, 32'h0);
      check_eq("lk_gnt0_c", {30'd0, gnt1, gnt0}, 32'd1);
      step(1'b1, 1'b0, 8'h05, 32'h0, 1'b1, 1'b0, 8'h06, 32'h0);
      check_eq("lk_release", {30'd0, gnt1, gnt0}, 32'd2);
      idle(3);
`endif

      // Reset asserted while a read is in flight.
      step(1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
      check_eq("mid_gnt0", {31'd0, gnt0}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0; req0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("mid_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_mem_we", {31'd0, mem_we}, 32'd0);
      step(1'b1, 1'b0, 8'h31, 32'h0, 1'b1, 1'b0, 8'h32, 32'h0);
      check_eq("post_tie", {30'd0, gnt1, gnt0}, 32'd1);
      idle(4);

      check_eq("sb_drain", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
